memory_access_stage: RTL and testbench
======================================

// Module: memory_access_stage
// PURPOSE
// - MEM pipeline stage directly downstream of execute: registers the execute outputs, performs the data-memory
//   load/store over a req/ack handshake, and selects the writeback value.
// - Stalls the upstream pipeline while an access is outstanding; inserts bubbles toward writeback.
// PARAMETERS
// - TIMEOUT  16  cycles in BUSY without mem_ack before abort; 0 disables the timeout
// PORTS
// - clk                 in   1   rising-edge clock
// - reset               in   1   asynchronous, active-low reset
// - bundle_in           in   8   ctrl: [0]mem_read [1]mem_write [2]reg_write [3]mem_to_reg [5:4]size 00=word 01=half 10=byte
//                                [6]load sign-extend [7]link
// - pc_seq_in           in   32  sequential PC (link value)
// - alu_in              in   32  ALU result / effective address
// - store_data_in       in   32  rt value for stores
// - reg_write_dest_in   in   5   destination register
// - stall_out           out  1   1 = upstream must hold its inputs
// - mem_req/mem_we      out  1   request / write strobe
// - mem_addr            out  32  {alu[31:2],2'b00}
// - mem_wdata/mem_be    out  32/4  store data, byte enables
// - mem_ack/mem_rdata   in   1/32  completion, read word
// - reg_write_out       out  1   writeback enable (qualified)
// - reg_write_dest_out  out  5   registered dest
// - result_out          out  32  writeback value
// - misalign_out        out  1   misaligned access this cycle
// - bus_error_out       out  1   one-cycle pulse on timeout abort
// BEHAVIOUR
// - Stage regs (bundle, pc, alu, store data, dest, valid) load every edge when stall_out=0; hold when 1.
// - Reset: all stage regs, FSM=IDLE, counter, load reg, mem_req, bus_error_out = 0; all outputs 0.
// - Alignment: word needs alu[1:0]=0, half needs alu[0]=0; else misalign_out=1, no request, reg_write_out=0.
// - FSM IDLE->BUSY on the capturing edge when incoming op has read|write and is aligned; mem_req/mem_we registered 1.
// - BUSY: stall_out=1, mem_req held, addr/wdata/be stable. Edge with mem_ack=1: latch mem_rdata, req=0, ->IDLE.
// - Latency: access occupies 1+k cycles (k = cycles until ack); non-memory ops pass in 1 cycle, no stall.
// - Timeout: counter counts BUSY cycles; at TIMEOUT without ack -> req=0, ->IDLE, bus_error_out=1 one cycle,
//   load data=0, reg_write_out=0 for that op. mem_ack on the same edge as timeout wins (normal completion).
// - mem_ack while IDLE is ignored. reset mid-BUSY drops mem_req immediately (async).
// - Stores (little-endian lanes): byte be=1<<alu[1:0], wdata={4{b[7:0]}}; half be=alu[1]?1100:0011,
//   wdata={2{b[15:0]}}; word be=1111, wdata=b.
// - Loads: extract lane by alu[1:0]/size; zero- or sign-extend per bundle[6].
// - result_out: link ? pc_seq : mem_to_reg ? load data : alu.
// - reg_write_out = valid & bundle[2] & ~stall_out & ~misalign & ~abort; during BUSY it is 0 (bubble).
// TESTING
// - ALU op alu=0x1234, reg_write=1, dest=5 -> next cycle result=0x1234, reg_write_out=1, stall_out=0.
// - lw alu=0x100, ack after 3 cycles, rdata=0xDEADBEEF -> stall 3 cycles, then result=0xDEADBEEF, dest valid.
// - lb signed alu=0x103, rdata=0x80FFFFFF -> be n/a, result=0xFFFFFF80; lbu -> 0x00000080.
// - sh alu=0x102, b=0x0000ABCD -> mem_be=1100, mem_wdata=0xABCDABCD, mem_we=1, reg_write_out=0.
// - lw alu=0x101 -> misalign_out=1, mem_req never asserts, reg_write_out=0.
// - lw with no ack, TIMEOUT=16 -> req drops after 16 BUSY cycles, bus_error_out one pulse; reset mid-BUSY -> req=0 at once.

Source files
------------

// File: rtl/memory_access_stage.sv
// MEM pipeline stage: registers execute outputs, runs one data-memory access over
// req/ack (with an optional timeout abort), and selects the writeback value.
module memory_access_stage #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  bundle_in,
  input  logic [31:0] pc_seq_in,
  input  logic [31:0] alu_in,
  input  logic [31:0] store_data_in,
  input  logic [4:0]  reg_write_dest_in,
  output logic        stall_out,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        reg_write_out,
  output logic [4:0]  reg_write_dest_out,
  output logic [31:0] result_out,
  output logic        misalign_out,
  output logic        bus_error_out
);

  typedef enum logic {IDLE, BUSY} state_t;
  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  state_t        state_q, state_d;
  logic [7:0]    bundle_q, bundle_d;
  logic [31:0]   pc_q, pc_d, alu_q, alu_d, sd_q, sd_d, load_q, load_d;
  logic [4:0]    dest_q, dest_d;
  logic          valid_q, valid_d, req_q, req_d, we_q, we_d, berr_q, berr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] a);
    case (size)
      2'b01:   return a[0];
      2'b10:   return 1'b0;
      default: return a != 2'b00;
    endcase
  endfunction

  logic in_go, stage_mis;
  logic [3:0]  be;
  logic [31:0] wdata, ld_val;
  logic [15:0] ld_half;
  logic [7:0]  ld_byte;

  assign stall_out = (state_q == BUSY);
  assign in_go     = (bundle_in[0] | bundle_in[1]) & ~misaligned(bundle_in[5:4], alu_in[1:0]);
  assign stage_mis = valid_q & (bundle_q[0] | bundle_q[1]) & misaligned(bundle_q[5:4], alu_q[1:0]);

  always_comb begin
    state_d  = state_q;
    bundle_d = bundle_q;
    pc_d     = pc_q;
    alu_d    = alu_q;
    sd_d     = sd_q;
    dest_d   = dest_q;
    valid_d  = valid_q;
    load_d   = load_q;
    req_d    = req_q;
    we_d     = we_q;
    cnt_d    = cnt_q;
    berr_d   = 1'b0;
    if (state_q == IDLE) begin
      bundle_d = bundle_in;
      pc_d     = pc_seq_in;
      alu_d    = alu_in;
      sd_d     = store_data_in;
      dest_d   = reg_write_dest_in;
      valid_d  = 1'b1;
      if (in_go) begin
        state_d = BUSY;
        req_d   = 1'b1;
        we_d    = bundle_in[1];
        cnt_d   = '0;
      end
    end else begin
      // ack on the timeout edge counts as a normal completion
      if (mem_ack) begin
        load_d  = mem_rdata;
        req_d   = 1'b0;
        we_d    = 1'b0;
        cnt_d   = '0;
        state_d = IDLE;
      end else if (TIMEOUT != 0 && cnt_q == CW'(TIMEOUT - 1)) begin
        load_d  = '0;
        req_d   = 1'b0;
        we_d    = 1'b0;
        cnt_d   = '0;
        berr_d  = 1'b1;
        state_d = IDLE;
      end else if (TIMEOUT != 0) begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      bundle_q <= '0;
      pc_q     <= '0;
      alu_q    <= '0;
      sd_q     <= '0;
      dest_q   <= '0;
      valid_q  <= 1'b0;
      load_q   <= '0;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      cnt_q    <= '0;
      berr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      bundle_q <= bundle_d;
      pc_q     <= pc_d;
      alu_q    <= alu_d;
      sd_q     <= sd_d;
      dest_q   <= dest_d;
      valid_q  <= valid_d;
      load_q   <= load_d;
      req_q    <= req_d;
      we_q     <= we_d;
      cnt_q    <= cnt_d;
      berr_q   <= berr_d;
    end
  end

  // little-endian lane steering for stores
  always_comb begin
    be    = 4'b1111;
    wdata = sd_q;
    case (bundle_q[5:4])
      2'b10: begin
        be    = 4'b0001 << alu_q[1:0];
        wdata = {4{sd_q[7:0]}};
      end
      2'b01: begin
        be    = alu_q[1] ? 4'b1100 : 4'b0011;
        wdata = {2{sd_q[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    ld_byte = load_q[8*alu_q[1:0] +: 8];
    ld_half = alu_q[1] ? load_q[31:16] : load_q[15:0];
    case (bundle_q[5:4])
      2'b10:   ld_val = bundle_q[6] ? {{24{ld_byte[7]}}, ld_byte} : {24'b0, ld_byte};
      2'b01:   ld_val = bundle_q[6] ? {{16{ld_half[15]}}, ld_half} : {16'b0, ld_half};
      default: ld_val = load_q;
    endcase
  end

  assign mem_req            = req_q;
  assign mem_we             = we_q;
  assign mem_addr           = {alu_q[31:2], 2'b00};
  assign mem_wdata          = wdata;
  assign mem_be             = req_q ? be : 4'b0000;
  assign misalign_out       = stage_mis;
  assign bus_error_out      = berr_q;
  assign reg_write_dest_out = dest_q;
  assign result_out         = bundle_q[7] ? pc_q : (bundle_q[3] ? ld_val : alu_q);
  // berr_q marks the op that was just aborted; it must not write back
  assign reg_write_out      = valid_q & bundle_q[2] & ~stall_out & ~stage_mis & ~berr_q;

endmodule

// File: tb/tb_memory_access_stage.sv
// Directed bench for memory_access_stage: per-op spec model drives a per-cycle
// expectation set that a negedge compare process checks, plus literal pins.
module tb_memory_access_stage;
  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  bundle_in;
  logic [31:0] pc_seq_in, alu_in, store_data_in, mem_rdata;
  logic [4:0]  reg_write_dest_in;
  logic        stall_out, mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, result_out;
  logic [3:0]  mem_be;
  logic        reg_write_out, misalign_out, bus_error_out;
  logic [4:0]  reg_write_dest_out;

  memory_access_stage #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .bundle_in(bundle_in), .pc_seq_in(pc_seq_in),
    .alu_in(alu_in), .store_data_in(store_data_in), .reg_write_dest_in(reg_write_dest_in),
    .stall_out(stall_out), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .reg_write_out(reg_write_out), .reg_write_dest_out(reg_write_dest_out),
    .result_out(result_out), .misalign_out(misalign_out), .bus_error_out(bus_error_out)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  // per-cycle expectations, set by the driver at posedge+1
  logic        exp_en = 1'b0;
  logic        e_stall, e_req, e_we, e_mis, e_rw, e_berr;
  logic [31:0] e_addr, e_wdata, e_res;
  logic [3:0]  e_be;
  logic [4:0]  e_dst;

  always @(negedge clk) if (exp_en) begin
    chk("stall", {31'b0, stall_out}, {31'b0, e_stall});
    chk("req", {31'b0, mem_req}, {31'b0, e_req});
    chk("we", {31'b0, mem_we}, {31'b0, e_we});
    chk("misalign", {31'b0, misalign_out}, {31'b0, e_mis});
    chk("reg_write", {31'b0, reg_write_out}, {31'b0, e_rw});
    chk("bus_error", {31'b0, bus_error_out}, {31'b0, e_berr});
    if (e_req) chk("addr", mem_addr, e_addr);
    if (e_req && e_we) begin
      chk("be", {28'b0, mem_be}, {28'b0, e_be});
      chk("wdata", mem_wdata, e_wdata);
    end
    if (e_rw) begin
      chk("result", result_out, e_res);
      chk("dest", {27'b0, reg_write_dest_out}, {27'b0, e_dst});
    end
  end

  function automatic int nbytes(input logic [1:0] size);
    return (size == 2'b10) ? 1 : (size == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [3:0] model_be(input logic [1:0] size, input logic [31:0] a);
    int n, off;
    logic [3:0] r;
    n = nbytes(size); off = int'(a % 4);
    for (int i = 0; i < 4; i++) r[i] = (i >= off) && (i < off + n);
    return r;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [1:0] size, input logic [31:0] d);
    int n;
    logic [31:0] r;
    n = nbytes(size);
    for (int i = 0; i < 4; i++) r[8*i +: 8] = d[8*(i % n) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] w, input logic [1:0] size,
                                             input logic [31:0] a, input logic sgn);
    int n;
    longint full, v;
    n = nbytes(size);
    full = longint'(1) << (8 * n);
    v = (longint'({32'b0, w}) >> (8 * (a % 4))) & (full - 1);
    if (sgn && v >= full / 2) v = v - full;
    return v[31:0];
  endfunction

  function automatic logic [7:0] mk(input logic rd, wr, rw, m2r, input logic [1:0] sz,
                                    input logic sgn, lnk);
    return {lnk, sgn, sz, m2r, rw, wr, rd};
  endfunction

  int          seen_stalls;
  logic [3:0]  seen_be;
  logic [31:0] seen_wdata;
  logic        seen_we;

  // k: ack asserted in the k-th BUSY cycle; 0 = never acknowledged
  task automatic run_op(input logic [7:0] b, input logic [31:0] pc, alu, sd, input logic [4:0] dst,
                        input int k, input logic [31:0] rdata, input logic ack_idle);
    logic memop, mis, abort;
    logic [31:0] ld;
    bundle_in = b; pc_seq_in = pc; alu_in = alu; store_data_in = sd; reg_write_dest_in = dst;
    mem_rdata = rdata; mem_ack = ack_idle;
    memop = b[0] | b[1];
    mis = memop && (alu % nbytes(b[5:4]) != 0);
    abort = 1'b0; seen_stalls = 0; ld = '0;
    @(posedge clk); #1;
    if (memop && !mis) begin
      e_stall = 1; e_req = 1; e_we = b[1]; e_mis = 0; e_rw = 0; e_berr = 0;
      e_addr = alu & ~32'd3; e_be = model_be(b[5:4], alu); e_wdata = model_wdata(b[5:4], sd);
      exp_en = 1;
      seen_be = mem_be; seen_wdata = mem_wdata; seen_we = mem_we;
      for (int c = 1; c <= 1000; c++) begin
        seen_stalls += int'(stall_out);
        mem_ack = (c == k);
        @(posedge clk); #1;
        if (c == k) break;
        if (TIMEOUT != 0 && c == TIMEOUT) begin abort = 1'b1; break; end
        if (c == 1000) chk("busy_bound", 32'd1, 32'd0);
      end
      mem_ack = 1'b0;
      ld = abort ? 32'd0 : model_load(rdata, b[5:4], alu, b[6]);
    end
    e_stall = 0; e_req = 0; e_we = 0; e_mis = mis; e_rw = b[2] & ~mis & ~abort;
    e_berr = abort; e_dst = dst;
    e_res = b[7] ? pc : (b[3] ? ld : alu);
    exp_en = 1;
  endtask

  logic [7:0] ALU, LW, LB, LBU, LH, SH, SB, SW, JAL;

  initial begin
    ALU = mk(0,0,1,0,2'b00,0,0); LW = mk(1,0,1,1,2'b00,0,0); LB = mk(1,0,1,1,2'b10,1,0);
    LBU = mk(1,0,1,1,2'b10,0,0); LH = mk(1,0,1,1,2'b01,1,0); SH = mk(0,1,0,0,2'b01,0,0);
    SB = mk(0,1,0,0,2'b10,0,0); SW = mk(0,1,0,0,2'b00,0,0); JAL = mk(0,0,1,0,2'b00,0,1);
    reset = 1'b0; bundle_in = '0; pc_seq_in = '0; alu_in = '0; store_data_in = '0;
    reg_write_dest_in = '0; mem_ack = 1'b0; mem_rdata = '0;
    repeat (2) @(posedge clk); #1;
    chk("rst_stall", {31'b0, stall_out}, 32'd0);
    chk("rst_req", {31'b0, mem_req}, 32'd0);
    chk("rst_be", {28'b0, mem_be}, 32'd0);
    chk("rst_result", result_out, 32'd0);
    chk("rst_rw", {31'b0, reg_write_out}, 32'd0);
    chk("rst_berr", {31'b0, bus_error_out}, 32'd0);
    reset = 1'b1;

    run_op(ALU, 32'h40, 32'h1234, 32'h0, 5'd5, 0, 32'h0, 0);
    chk("alu_result_lit", result_out, 32'h0000_1234);
    chk("alu_rw_lit", {31'b0, reg_write_out}, 32'd1);

    run_op(LW, 32'h44, 32'h100, 32'h0, 5'd7, 3, 32'hDEADBEEF, 0);
    chk("lw_stalls_lit", seen_stalls, 32'd3);
    chk("lw_result_lit", result_out, 32'hDEADBEEF);

    run_op(LB, 32'h48, 32'h103, 32'h0, 5'd8, 1, 32'h80FFFFFF, 0);
    chk("lb_result_lit", result_out, 32'hFFFFFF80);
    run_op(LBU, 32'h4C, 32'h103, 32'h0, 5'd9, 2, 32'h80FFFFFF, 0);
    chk("lbu_result_lit", result_out, 32'h0000_0080);

    run_op(SH, 32'h50, 32'h102, 32'h0000ABCD, 5'd0, 1, 32'h0, 0);
    chk("sh_be_lit", {28'b0, seen_be}, 32'hC);
    chk("sh_wdata_lit", seen_wdata, 32'hABCDABCD);
    chk("sh_we_lit", {31'b0, seen_we}, 32'd1);

    run_op(LW, 32'h54, 32'h101, 32'h0, 5'd10, 1, 32'h0, 0);
    chk("mis_lit", {31'b0, misalign_out}, 32'd1);

    run_op(LH, 32'h58, 32'h102, 32'h0, 5'd11, 2, 32'h8001_1234, 0);
    run_op(SB, 32'h5C, 32'h101, 32'h0000_00A5, 5'd0, 4, 32'h0, 0);
    run_op(SW, 32'h60, 32'h204, 32'h1122_3344, 5'd0, 1, 32'h0, 0);
    run_op(JAL, 32'h68, 32'h999, 32'h0, 5'd31, 0, 32'h0, 1);   // ack while IDLE ignored
    run_op(SH, 32'h6C, 32'h101, 32'h1, 5'd0, 1, 32'h0, 0);     // misaligned store
    run_op(LW, 32'h70, 32'h300, 32'h0, 5'd12, TIMEOUT, 32'h0BAD_F00D, 0);
    chk("tie_result_lit", result_out, 32'h0BAD_F00D);

    run_op(LW, 32'h74, 32'h400, 32'h0, 5'd13, 0, 32'h5555_5555, 0);
    chk("timeout_berr_lit", {31'b0, bus_error_out}, 32'd1);
    chk("timeout_result_lit", result_out, 32'd0);
    run_op(ALU, 32'h78, 32'h7, 32'h0, 5'd14, 0, 32'h0, 0);

    // async reset in the middle of an outstanding access
    bundle_in = LW; alu_in = 32'h500; mem_ack = 1'b0;
    @(posedge clk); #1;
    exp_en = 0;
    repeat (3) @(posedge clk);
    #3 reset = 1'b0;
    #1;
    chk("rst_busy_req", {31'b0, mem_req}, 32'd0);
    chk("rst_busy_stall", {31'b0, stall_out}, 32'd0);
    bundle_in = '0;
    @(posedge clk); #1;
    reset = 1'b1;
    run_op(ALU, 32'h80, 32'hCAFE, 32'h0, 5'd3, 0, 32'h0, 0);
    @(posedge clk); #1;
    exp_en = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
